// File: rtl/raptor_pkg.sv
// Shared types and helpers for the raptor front end.
//   XLEN          : architectural address/data width
//   NOP_INST      : canonical NOP (addi x0, x0, 0) carried by fault entries
//   fetch_state_t : fetch FSM state encoding
//   fetch_entry_t : one instruction-buffer entry {inst, pc, fault}
//   pc_incr       : sequential next-PC, wraps modulo 2^XLEN
//   pc_misaligned : true when an address is not word aligned
package raptor_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode.
//   clk, reset : clock, synchronous active-high reset (pointers/count only)
//   flush      : empties the buffer; a push in the same cycle lands in slot 0
//   push       : write push_data (caller guarantees space)
//   pop        : consume the head entry (ignored when empty or flushing)
//   out_valid  : buffer non-empty
//   out_data   : head entry, driven from storage registers only
//   count      : number of valid entries
module fetch_fifo
  import raptor_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output logic                     out_valid,
  output entry_t                   out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;
  logic            do_pop;

  assign do_pop    = pop & (count != '0) & ~flush;
  assign out_valid = (count != '0);
  assign out_data  = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= push ? AW'(1) : '0;
      count <= push ? CW'(1) : '0;
    end else begin
      if (push)   wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[flush ? '0 : wptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequences the PC register, issues one read at a
// time to instruction memory, buffers responses and hands them to decode.
//   clk, reset              : clock, synchronous active-high reset
//   pc_i / pc_next_o/pc_we_o: PC register read value, load value, load enable
//   imem_req_o/addr_o       : read request and address (address = pc_i)
//   imem_gnt_i              : request accepted this cycle
//   imem_rvalid_i/rdata_i   : read response
//   imem_err_i              : access fault, qualified by imem_rvalid_i
//   redirect_i/redirect_pc_i: branch/jump/trap redirect and its target
//   inst_valid_o/ready_i    : decode handshake
//   inst_o/inst_pc_o        : instruction word and its PC
//   inst_fault_o            : entry is a fault marker (inst_o is a NOP)
module fetch_unit
  import raptor_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            pc_we_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            imem_err_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_fault_o
);

  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t     state;
  fetch_state_t     state_n;
  logic [XLEN-1:0]  inflight_pc_p1;
  logic             capture;

  logic             fifo_push;
  logic             fifo_flush;
  logic             fifo_pop;
  logic             fifo_valid;
  logic [CW-1:0]    fifo_count;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  // Issue stage -> response stage: remember which PC the outstanding read is for.
  always_ff @(posedge clk) begin
    if (capture) inflight_pc_p1 <= pc_i;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    pc_we_o    = 1'b0;
    pc_next_o  = '0;
    imem_req_o = 1'b0;
    capture    = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    push_entry = '{inst: NOP_INST, pc: inflight_pc_p1, fault: 1'b0};

    if (!reset) begin
      case (state)
        IDLE: begin
          pc_we_o   = 1'b1;
          pc_next_o = RESET_VECTOR;
          state_n   = REQ;
        end
        REQ: begin
          // Space is reserved at issue time so a response can always be pushed.
          imem_req_o = (fifo_count < DEPTH_C);
          if (imem_req_o && imem_gnt_i) begin
            pc_we_o   = 1'b1;
            pc_next_o = pc_incr(pc_i);
            capture   = 1'b1;
            state_n   = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            fifo_push = 1'b1;
            if (imem_err_i) begin
              push_entry = '{inst: NOP_INST, pc: inflight_pc_p1, fault: 1'b1};
              state_n    = HALT;
            end else begin
              push_entry = '{inst: imem_rdata_i, pc: inflight_pc_p1, fault: 1'b0};
              state_n    = REQ;
            end
          end
        end
        DRAIN: begin
          // The stale response of the pre-redirect read is dropped here.
          if (imem_rvalid_i) state_n = REQ;
        end
        HALT: ;
        default: state_n = IDLE;
      endcase

      // Redirect overrides everything except the reset-vector load.
      if (redirect_i && state != IDLE) begin
        imem_req_o = 1'b0;
        capture    = 1'b0;
        pc_we_o    = 1'b1;
        pc_next_o  = redirect_pc_i;
        fifo_flush = 1'b1;
        fifo_push  = 1'b0;
        if (pc_misaligned(redirect_pc_i)) begin
          fifo_push  = 1'b1;
          push_entry = '{inst: NOP_INST, pc: redirect_pc_i, fault: 1'b1};
          state_n    = HALT;
        end else if ((state == WAIT || state == DRAIN) && !imem_rvalid_i) begin
          // A read is still in flight; its response must not be delivered.
          state_n = DRAIN;
        end else begin
          state_n = REQ;
        end
      end
    end
  end

  assign fifo_pop = inst_valid_o & inst_ready_i;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .out_valid (fifo_valid),
    .out_data  (head),
    .count     (fifo_count)
  );

  // Buffer output stage -> decode; everything reads zero while in reset.
  assign imem_addr_o  = reset ? '0 : pc_i;
  assign inst_valid_o = ~reset & fifo_valid;
  assign inst_o       = reset ? '0 : head.inst;
  assign inst_pc_o    = reset ? '0 : head.pc;
  assign inst_fault_o = ~reset & head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic [31:0] pc_next_o;
  logic        pc_we_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_err_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_fault_o;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .FIFO_DEPTH   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_i          (pc_i),
    .pc_next_o     (pc_next_o),
    .pc_we_o       (pc_we_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .imem_err_i    (imem_err_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_fault_o  (inst_fault_o)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // memory model state
  int          lat = 1;
  logic        pend_valid = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;

  // per-cycle samples
  logic        s_req, s_we, s_ivalid, s_granted;
  logic [31:0] s_pc_next, s_addr;

  logic        gap_chk = 1'b0;
  int          last_hs = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic fault);
    exp_t e;
    e.inst  = fault ? 32'h0000_0013 : mem_word(pc);
    e.pc    = pc;
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  // One clock: sample and score at the falling edge, then apply the memory
  // response and the PC register update just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    imem_gnt_i = imem_req_o;
    #1;
    s_req     = imem_req_o;
    s_we      = pc_we_o;
    s_pc_next = pc_next_o;
    s_addr    = imem_addr_o;
    s_ivalid  = inst_valid_o;
    s_granted = imem_req_o & imem_gnt_i;
    if (s_req) begin
      check("one_outstanding", 64'(pend_valid), 64'd0);
      check("addr_is_pc", 64'(imem_addr_o), 64'(pc_i));
    end
    if (inst_valid_o && inst_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_inst", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("inst", 64'(inst_o), 64'(e.inst));
        check("inst_pc", 64'(inst_pc_o), 64'(e.pc));
        check("inst_fault", 64'(inst_fault_o), 64'(e.fault));
      end
      if (gap_chk) begin
        if (last_hs >= 0) check("throughput_gap", 64'(cyc - last_hs), 64'd2);
        last_hs = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_gnt_i = 1'b0;
    if (s_we) pc_i = s_pc_next;
    if (s_granted) begin
      pend_valid = 1'b1;
      pend_addr  = s_addr;
      pend_cnt   = lat;
    end
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    imem_err_i    = 1'b0;
    if (pend_valid) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend_addr);
        imem_err_i    = err_en && (pend_addr == err_addr);
        pend_valid    = 1'b0;
      end
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    inst_ready_i = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
    inst_ready_i = 1'b0;
    check(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic wait_grant(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = s_granted;
    end
    check(tag, 64'(found), 64'd1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_pc_i = target;
    redirect_i    = 1'b1;
    cycle();
    redirect_i    = 1'b0;
  endtask

  task automatic count_reqs(input string tag, input int n);
    int r;
    r = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (s_req) r++;
    end
    check(tag, 64'(r), 64'd0);
  endtask

  initial begin
    int g;
    int late;
    reset         = 1'b1;
    pc_i          = 32'hDEAD_BEE0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    imem_err_i    = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    inst_ready_i  = 1'b0;

    // reset values
    cycle();
    check("rst_pc_we", 64'(s_we), 64'd0);
    check("rst_req", 64'(s_req), 64'd0);
    check("rst_inst_valid", 64'(s_ivalid), 64'd0);
    check("rst_pc_next", 64'(s_pc_next), 64'd0);
    check("rst_addr", 64'(s_addr), 64'd0);
    cycle();
    reset = 1'b0;

    // sequential fetch, 1-cycle memory, decode always ready
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    push_exp(32'h8, 1'b0);
    gap_chk = 1'b1;
    last_hs = -1;
    cycle();
    check("idle_pc_we", 64'(s_we), 64'd1);
    check("idle_pc_next", 64'(s_pc_next), 64'd0);
    wait_drain("seq_drain", 40);
    gap_chk = 1'b0;

    // backpressure: only FIFO_DEPTH reads issued, then resume without loss
    for (int i = 0; i < 8; i++) cycle();
    do_redirect(32'h40);
    check("redir40_pc_we", 64'(s_we), 64'd1);
    check("redir40_pc_next", 64'(s_pc_next), 64'h40);
    g = 0;
    late = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (s_granted) g++;
      if (i >= 8 && s_req) late++;
    end
    check("stall_grants", 64'(g), 64'd2);
    check("stall_req_quiet", 64'(late), 64'd0);
    push_exp(32'h40, 1'b0);
    push_exp(32'h44, 1'b0);
    push_exp(32'h48, 1'b0);
    push_exp(32'h4C, 1'b0);
    wait_drain("stall_drain", 40);

    // redirect while a read is outstanding: flush and drain stale response
    for (int i = 0; i < 8; i++) cycle();
    lat = 3;
    push_exp(32'h50, 1'b0);
    inst_ready_i = 1'b1;
    cycle();
    inst_ready_i = 1'b0;
    check("pop_one", 64'(exp_q.size()), 64'd0);
    wait_grant("grant_58");
    check("grant_58_addr", 64'(s_addr), 64'h58);
    do_redirect(32'h100);
    check("wait_redir_valid_before", 64'(s_ivalid), 64'd1);
    check("wait_redir_pc_next", 64'(s_pc_next), 64'h100);
    cycle();
    check("flush_valid_after", 64'(s_ivalid), 64'd0);
    check("drain_no_req", 64'(s_req), 64'd0);
    push_exp(32'h100, 1'b0);
    push_exp(32'h104, 1'b0);
    wait_drain("drain_drain", 60);

    // access fault at 0x8, halt, then restart by redirect
    lat = 1;
    err_en = 1'b1;
    err_addr = 32'h8;
    do_redirect(32'h0);
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    push_exp(32'h8, 1'b1);
    wait_drain("fault_drain", 60);
    inst_ready_i = 1'b1;
    count_reqs("halt_no_req", 10);
    inst_ready_i = 1'b0;
    err_en = 1'b0;
    do_redirect(32'h20);
    push_exp(32'h20, 1'b0);
    push_exp(32'h24, 1'b0);
    wait_drain("restart_drain", 40);

    // PC wrap at the top of the address space
    do_redirect(32'hFFFF_FFFC);
    wait_grant("grant_wrap");
    check("wrap_addr", 64'(s_addr), 64'hFFFF_FFFC);
    check("wrap_pc_next", 64'(s_pc_next), 64'h0);
    push_exp(32'hFFFF_FFFC, 1'b0);
    push_exp(32'h0, 1'b0);
    wait_drain("wrap_drain", 40);

    // misaligned redirect target
    do_redirect(32'h102);
    check("misalign_no_req", 64'(s_req), 64'd0);
    cycle();
    check("misalign_valid", 64'(s_ivalid), 64'd1);
    push_exp(32'h102, 1'b1);
    wait_drain("misalign_drain", 10);
    inst_ready_i = 1'b1;
    count_reqs("misalign_halt", 8);
    inst_ready_i = 1'b0;

    // reset in the middle of an outstanding read
    lat = 2;
    do_redirect(32'h200);
    wait_grant("grant_200");
    check("grant_200_addr", 64'(s_addr), 64'h200);
    reset = 1'b1;
    cycle();
    check("midrst_pc_we", 64'(s_we), 64'd0);
    check("midrst_req", 64'(s_req), 64'd0);
    reset = 1'b0;
    cycle();
    check("postrst_valid", 64'(s_ivalid), 64'd0);
    check("postrst_pc_we", 64'(s_we), 64'd1);
    check("postrst_pc_next", 64'(s_pc_next), 64'h0);
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    wait_drain("postrst_drain", 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
